// File: rtl/rr_arb_mux_nbit.sv
// CH-to-1 N-bit multiplexer with internal round-robin or fixed-priority arbitration
// feeding a single-entry output register with valid/ready handshake on both sides.
module rr_arb_mux_nbit #(
   parameter int N  = 64,
   parameter int CH = 4,
   parameter int RR = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CH-1:0]   in_valid,
   input  logic [CH*N-1:0] in_data,
   output logic [CH-1:0]   in_ready,
   output logic            out_valid,
   output logic [N-1:0]    out_data,
   output logic [2:0]      out_sel,
   input  logic            out_ready
);

   localparam int PW = (CH > 1) ? $clog2(CH) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_data_q, out_data_d;
   logic [2:0]    out_sel_q, out_sel_d;

   logic          accept;
   logic          grant_any;
   logic [PW-1:0] grant_idx;

   // The output slot can take a word when it is empty or being drained this cycle.
   assign accept = ~out_valid_q | out_ready;

   always_comb begin : arbiter
      int start;
      int idx;
      in_ready  = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      start     = (RR != 0) ? int'(ptr_q) : 0;
      idx       = 0;
      if (accept && !reset) begin
         for (int k = 0; k < CH; k++) begin
            idx = (start + k) % CH;
            if (!grant_any && in_valid[idx]) begin
               grant_any     = 1'b1;
               grant_idx     = idx[PW-1:0];
               in_ready[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin : next_state
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (grant_any) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(grant_idx)*N +: N];
         out_sel_d   = 3'(grant_idx);
         if (RR != 0) begin
            ptr_d = (grant_idx == PW'(CH-1)) ? '0 : grant_idx + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux_nbit.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus
// and are compared against a queue-free behavioural model of the arbitration rules.
module tb_rr_arb_mux_nbit;

   localparam int N  = 64;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH-1:0]   in_valid;
   logic [CH*N-1:0] in_data;
   logic            out_ready;

   logic [CH-1:0]   in_ready_rr, in_ready_fp;
   logic            out_valid_rr, out_valid_fp;
   logic [N-1:0]    out_data_rr, out_data_fp;
   logic [2:0]      out_sel_rr, out_sel_fp;

   int total = 0;
   int bad   = 0;

   // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
   int           m_ptr [2];
   bit           m_valid [2];
   logic [N-1:0] m_data [2];
   int           m_sel [2];

   always #5 clk = ~clk;

   rr_arb_mux_nbit #(.N(N), .CH(CH), .RR(1)) dut_rr (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_rr), .out_valid(out_valid_rr), .out_data(out_data_rr),
      .out_sel(out_sel_rr), .out_ready(out_ready)
   );

   rr_arb_mux_nbit #(.N(N), .CH(CH), .RR(0)) dut_fp (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_fp), .out_valid(out_valid_fp), .out_data(out_data_fp),
      .out_sel(out_sel_fp), .out_ready(out_ready)
   );

   // Which channel the model would grant this cycle, or -1 for none.
   function automatic int pick(int m);
      int start;
      if (reset || (m_valid[m] && !out_ready)) return -1;
      start = (m == 0) ? m_ptr[m] : 0;
      for (int k = 0; k < CH; k++)
         if (in_valid[(start + k) % CH]) return (start + k) % CH;
      return -1;
   endfunction

   function automatic void model_advance();
      int g;
      for (int m = 0; m < 2; m++) begin
         g = pick(m);
         if (reset) begin
            m_ptr[m] = 0; m_valid[m] = 0; m_data[m] = '0; m_sel[m] = 0;
         end else if (g >= 0) begin
            m_valid[m] = 1;
            m_data[m]  = in_data[g*N +: N];
            m_sel[m]   = g;
            if (m == 0) m_ptr[m] = (g + 1) % CH;
         end else if (out_ready) begin
            m_valid[m] = 0;
         end
      end
   endfunction

   function automatic logic [143:0] model_vec();
      logic [143:0] v;
      int g;
      v = '0;
      for (int m = 0; m < 2; m++) begin
         g = pick(m);
         v[m*72 +: 72] = {(g >= 0) ? 4'(1 << g) : 4'b0, m_valid[m], m_data[m], 3'(m_sel[m])};
      end
      return v;
   endfunction

   function automatic logic [143:0] dut_vec();
      return {in_ready_fp, out_valid_fp, out_data_fp, out_sel_fp,
              in_ready_rr, out_valid_rr, out_data_rr, out_sel_rr};
   endfunction

   task automatic step();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [CH-1:0] v, input logic r, input logic rst);
      in_valid  = v;
      out_ready = r;
      reset     = rst;
      #1;
   endtask

   task automatic set_ch(input int c, input logic [N-1:0] d);
      in_data[c*N +: N] = d;
   endtask

   task automatic do_reset();
      drive('0, 1'b1, 1'b1);
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      drive(4'b1111, 1'b1, 1'b1);
      total++;
      if (in_ready_rr !== 4'b0 || in_ready_fp !== 4'b0) begin
         bad++; $display("[TB] FAIL reset_in_ready actual=%b/%b required=0000", in_ready_rr, in_ready_fp);
      end
      step();
      total++;
      if ({out_valid_rr, out_data_rr, out_sel_rr} !== '0) begin
         bad++; $display("[TB] FAIL reset_outputs actual=%b %h %0d required=0 0 0", out_valid_rr, out_data_rr, out_sel_rr);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      do_reset();
      set_ch(0, 64'hA);
      drive(4'b0001, 1'b1, 1'b0);
      total++;
      if (in_ready_rr !== 4'b0001) begin
         bad++; $display("[TB] FAIL basic_in_ready actual=%b required=0001", in_ready_rr);
      end
      step();
      drive(4'b0000, 1'b1, 1'b0);
      total++;
      if (out_valid_rr !== 1'b1 || out_data_rr !== 64'hA || out_sel_rr !== 3'd0) begin
         bad++; $display("[TB] FAIL basic_out actual=%b %h %0d required=1 a 0", out_valid_rr, out_data_rr, out_sel_rr);
      end
   endtask

   task automatic test_rr_sweep();
      do_reset();
      for (int c = 0; c < CH; c++) set_ch(c, 64'h100 + 64'(c));
      for (int i = 0; i < 8; i++) begin
         drive(4'b1111, 1'b1, 1'b0);
         total++;
         if (in_ready_rr !== 4'(1 << (i % 4)) || dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL rr_sweep_%0d actual=%b required=%b", i, in_ready_rr, 4'(1 << (i % 4)));
         end
         step();
         total++;
         if (out_valid_rr !== 1'b1 || out_sel_rr !== 3'(i % 4)) begin
            bad++; $display("[TB] FAIL rr_sweep_out_%0d actual=%b/%0d required=1/%0d", i, out_valid_rr, out_sel_rr, i % 4);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(4'b0100, 1'b1, 1'b0);
      step();
      drive(4'b0101, 1'b1, 1'b0);
      total++;
      if (in_ready_rr !== 4'b0001) begin
         bad++; $display("[TB] FAIL wrap_first actual=%b required=0001", in_ready_rr);
      end
      step();
      total++;
      if (in_ready_rr !== 4'b0100) begin
         bad++; $display("[TB] FAIL wrap_second actual=%b required=0100", in_ready_rr);
      end
      step();
   endtask

   task automatic test_stall();
      do_reset();
      set_ch(0, 64'h55);
      set_ch(1, 64'h11);
      drive(4'b0001, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0010, 1'b0, 1'b0);
         total++;
         if (in_ready_rr !== 4'b0 || out_data_rr !== 64'h55 || out_valid_rr !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_%0d actual=%b %h required=0000 55", i, in_ready_rr, out_data_rr);
         end
         step();
      end
      drive(4'b0010, 1'b1, 1'b0);
      total++;
      if (in_ready_rr !== 4'b0010) begin
         bad++; $display("[TB] FAIL stall_release actual=%b required=0010", in_ready_rr);
      end
      step();
      drive(4'b0000, 1'b0, 1'b0);
      total++;
      if (out_sel_rr !== 3'd1 || out_data_rr !== 64'h11) begin
         bad++; $display("[TB] FAIL stall_load actual=%0d %h required=1 11", out_sel_rr, out_data_rr);
      end
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b1010, 1'b1, 1'b0);
         total++;
         if (in_ready_fp !== 4'b0010 || dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL fixed_prio_%0d actual=%b required=0010", i, in_ready_fp);
         end
         step();
      end
   endtask

   task automatic test_reset_stall();
      do_reset();
      set_ch(0, 64'h77);
      drive(4'b0001, 1'b1, 1'b0);
      step();
      drive(4'b0000, 1'b0, 1'b0);
      step();
      drive(4'b1111, 1'b0, 1'b1);
      total++;
      if (in_ready_rr !== 4'b0 || in_ready_fp !== 4'b0) begin
         bad++; $display("[TB] FAIL reset_stall_rdy actual=%b/%b required=0000", in_ready_rr, in_ready_fp);
      end
      step();
      total++;
      if ({out_valid_rr, out_data_rr, out_sel_rr} !== '0) begin
         bad++; $display("[TB] FAIL reset_stall_out actual=%b %h %0d required=0 0 0", out_valid_rr, out_data_rr, out_sel_rr);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < CH; c++) set_ch(c, {$urandom, $urandom});
         drive(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL random_%0d actual=%h required=%h", i, dut_vec(), model_vec());
         end
         step();
      end
   endtask

   initial begin
      in_data   = '0;
      in_valid  = '0;
      out_ready = 1'b0;
      reset     = 1'b1;
      test_reset();
      test_basic();
      test_rr_sweep();
      test_wrap();
      test_stall();
      test_fixed_prio();
      test_reset_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
